// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor and the
// transmitter state encoding (also consumed by uart_rx).
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 104;  // 12 MHz / 115200 baud
  localparam int DATA_BITS            = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_CTS = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready handshake between a producer and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with optional active-low CTS# gating
// checked once before each start bit.
//
// state    | meaning
// IDLE     | line high, ready for a byte
// WAIT_CTS | byte latched, holding until host drops CTS#
// START    | driving start bit (0)
// DATA     | driving shift[0], one bit per baud period
// STOP     | driving stop bit (1); done pulses on exit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit USE_CTS      = 1'b1
) (
  input  logic            CLK,
  input  logic            reset,
  uart_tx_if.slave        bus,
  input  logic            cts,
  output logic            tx,
  output logic            done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 ready_q;
  logic                 cts_s;
  logic                 accept;
  logic                 cts_clear;
  logic                 baud_tick;

  // Resets to 1 so the link looks "not clear to send" until the host says otherwise.
  sync_2ff #(.RESET_VAL(1'b1)) u_cts_sync (
    .CLK   (CLK),
    .reset (reset),
    .d     (cts),
    .q     (cts_s)
  );

  assign bus.ready = ready_q;
  assign accept    = bus.data_valid && ready_q;
  assign cts_clear = !USE_CTS || !cts_s;
  assign baud_tick = (baud_cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      ready_q  <= 1'b1;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            shift    <= bus.data_in;
            ready_q  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (cts_clear) begin
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_WAIT_CTS;
            end
          end
        end

        ST_WAIT_CTS: begin
          tx <= 1'b1;
          if (cts_clear) begin
            state    <= ST_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
          end
        end

        ST_START: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            state    <= ST_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[DATA_BITS-1:1]};
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            done     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          ready_q  <= 1'b1;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random bytes,
// checked against a per-cycle frame model built from the 8N1 bit layout.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       reset;
  logic       cts;
  logic       sel;
  logic [7:0] din;
  logic       dv;
  logic       tx0, tx1, done0, done1;
  logic       tx_s, done_s, rdy_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  uart_tx_if if0 ();
  uart_tx_if if1 ();

  assign if0.data_in    = din;
  assign if1.data_in    = din;
  assign if0.data_valid = dv && !sel;
  assign if1.data_valid = dv && sel;

  assign tx_s   = sel ? tx1       : tx0;
  assign done_s = sel ? done1     : done0;
  assign rdy_s  = sel ? if1.ready : if0.ready;

  uart_tx #(.CLKS_PER_BIT(CPB), .USE_CTS(1'b1)) u_dut_cts (
    .CLK   (CLK),
    .reset (reset),
    .bus   (if0),
    .cts   (cts),
    .tx    (tx0),
    .done  (done0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .USE_CTS(1'b0)) u_dut_nocts (
    .CLK   (CLK),
    .reset (reset),
    .bus   (if1),
    .cts   (cts),
    .tx    (tx1),
    .done  (done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Frame position j: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // Offers a byte once ready, returns just after the accept edge.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    while (!rdy_s && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) chk("ready_timeout", 32'd0, 32'd1);
    din = b;
    dv  = 1'b1;
    tick();
    dv  = 1'b0;
    din = 8'($urandom);
  endtask

  // Checks the first ncyc cycles of a frame; optionally raises CTS# at the
  // first cycle of data bit cts_bit.
  task automatic run_bits(input logic [7:0] b, input int ncyc, input int cts_bit);
    for (int t = 0; t < ncyc; t++) begin
      if (cts_bit >= 0 && t == (cts_bit + 1) * CPB) cts = 1'b1;
      chk("tx_bit", 32'(tx_s), 32'(frame_bit(b, t / CPB)));
      chk("ready_busy", 32'(rdy_s), 32'd0);
      chk("done_busy", 32'(done_s), 32'd0);
      tick();
    end
  endtask

  task automatic check_end();
    chk("done_pulse", 32'(done_s), 32'd1);
    chk("ready_after", 32'(rdy_s), 32'd1);
    chk("tx_idle_after", 32'(tx_s), 32'd1);
  endtask

  task automatic full_frame(input logic [7:0] b);
    send(b);
    run_bits(b, 10 * CPB, -1);
    check_end();
  endtask

  initial begin
    logic [7:0] rb;
    reset = 1'b1;
    cts   = 1'b0;
    sel   = 1'b0;
    din   = 8'h00;
    dv    = 1'b0;
    tick();
    tick();
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_ready", 32'(if0.ready), 32'd1);
    chk("rst_done", 32'(done0), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_done_low", 32'(done0), 32'd0);

    full_frame(8'h55);
    tick();
    chk("single_done", 32'(done_s), 32'd0);
    full_frame(8'hA3);
    tick();

    // CTS flow control
    cts = 1'b1;
    repeat (3) tick();
    send(8'h41);
    for (int i = 0; i < 20; i++) begin
      chk("cts_hold_tx", 32'(tx_s), 32'd1);
      chk("cts_hold_ready", 32'(rdy_s), 32'd0);
      tick();
    end
    cts = 1'b0;
    tick();
    chk("cts_lat1", 32'(tx_s), 32'd1);
    tick();
    chk("cts_lat2", 32'(tx_s), 32'd1);
    tick();
    run_bits(8'h41, 10 * CPB, 2);
    check_end();
    cts = 1'b0;
    repeat (3) tick();

    // Back-to-back
    din = 8'h00;
    dv  = 1'b1;
    tick();
    din = 8'hFF;
    run_bits(8'h00, 10 * CPB, -1);
    check_end();
    tick();
    dv  = 1'b0;
    din = 8'($urandom);
    run_bits(8'hFF, 10 * CPB, -1);
    check_end();
    tick();

    // Reset mid-frame during data bit 3
    send(8'hF0);
    run_bits(8'hF0, 4 * CPB + 1, -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_tx", 32'(tx_s), 32'd1);
    chk("mid_rst_ready", 32'(rdy_s), 32'd1);
    for (int i = 0; i < 8 * CPB; i++) begin
      chk("mid_rst_no_done", 32'(done_s), 32'd0);
      chk("mid_rst_idle_tx", 32'(tx_s), 32'd1);
      tick();
    end
    full_frame(8'h0F);
    tick();

    // Random bytes with random gaps
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      rb = 8'($urandom);
      full_frame(rb);
      tick();
    end

    // USE_CTS = 0 ignores CTS#
    sel = 1'b1;
    cts = 1'b1;
    repeat (3) tick();
    full_frame(8'h99);
    tick();
    sel = 1'b0;
    cts = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
